// File: rtl/hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl
//
// Pipeline sequencer for the 5-stage core, sitting beside the forwarding unit.
// It resolves the hazards that forwarding cannot:
//   - load-use: one-cycle front-end stall with a bubble injected into ID/EX
//   - taken branch/jump in EX: flush IF/ID and bubble ID/EX
//   - multi-cycle EX ops (mul/div): freeze PC, IF/ID and ID/EX while EX/MEM
//     receives bubbles, until the unit reports done or a timeout expires
// It also keeps saturating stall/flush performance counters.
//
// Ports
//   clk              rising-edge clock
//   rst              synchronous reset, active-high
//   if_id_rs1/rs2    ID-stage source registers
//   if_id_use_rs1/2  ID instruction actually reads rs1/rs2
//   id_ex_mem_read   EX instruction is a load
//   id_ex_rd         EX instruction destination register
//   id_ex_mc_start   EX instruction is multi-cycle
//   mc_done          multi-cycle unit result valid this cycle
//   ex_branch_taken  branch/jump resolved taken in EX
//   pc_write         PC update enable
//   if_id_write      IF/ID write enable
//   id_ex_write      ID/EX write enable
//   id_ex_bubble     load NOP into ID/EX
//   if_id_flush      clear IF/ID to NOP
//   ex_mem_bubble    load NOP into EX/MEM
//   mc_timeout       sticky error: multi-cycle op exceeded MC_TIMEOUT cycles
//   stall_cnt        saturating count of cycles with pc_write==0
//   flush_cnt        saturating count of cycles with if_id_flush==1
//
// Strobes are combinational from state and inputs; state, wait counter,
// mc_timeout and the performance counters are registered.
// -----------------------------------------------------------------------------
module hazard_stall_ctrl #(
    parameter int CNT_W      = 32,
    parameter int MC_TIMEOUT = 64   // must be >= 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       if_id_rs1,
    input  logic [4:0]       if_id_rs2,
    input  logic             if_id_use_rs1,
    input  logic             if_id_use_rs2,
    input  logic             id_ex_mem_read,
    input  logic [4:0]       id_ex_rd,
    input  logic             id_ex_mc_start,
    input  logic             mc_done,
    input  logic             ex_branch_taken,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_write,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic             ex_mem_bubble,
    output logic             mc_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic {
        RUN     = 1'b0,
        MC_WAIT = 1'b1
    } state_t;

    localparam int                WAIT_W      = $clog2(MC_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_VAL = WAIT_W'(MC_TIMEOUT);

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt, wait_inc;
    logic              timeout_set;
    logic              load_use;

    // x0 is hard-wired zero, so a load targeting it never creates a hazard.
    assign load_use = id_ex_mem_read && (id_ex_rd != 5'd0) &&
                      ((if_id_use_rs1 && (id_ex_rd == if_id_rs1)) ||
                       (if_id_use_rs2 && (id_ex_rd == if_id_rs2)));

    assign wait_inc = wait_cnt + WAIT_W'(1);

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        id_ex_write   = 1'b1;
        id_ex_bubble  = 1'b0;
        if_id_flush   = 1'b0;
        ex_mem_bubble = 1'b0;
        state_nxt     = state;
        wait_nxt      = wait_cnt;
        timeout_set   = 1'b0;

        if (!rst) begin
            unique case (state)
                RUN: begin
                    if (ex_branch_taken) begin
                        // Flush wins; a multi-cycle start on the wrong path
                        // is squashed along with it.
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                    end else if (id_ex_mc_start && mc_done) begin
                        // Zero-latency op: result already available.
                    end else if (id_ex_mc_start) begin
                        pc_write      = 1'b0;
                        if_id_write   = 1'b0;
                        id_ex_write   = 1'b0;
                        ex_mem_bubble = 1'b1;
                        state_nxt     = MC_WAIT;
                        wait_nxt      = WAIT_W'(1);
                    end else if (load_use) begin
                        // The bubble clears mem_read in EX next cycle, so
                        // this stall lasts exactly one cycle.
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                    end
                end

                MC_WAIT: begin
                    // EX is frozen: branch and load-use are not evaluated.
                    if (mc_done) begin
                        state_nxt = RUN;
                    end else begin
                        pc_write      = 1'b0;
                        if_id_write   = 1'b0;
                        id_ex_write   = 1'b0;
                        ex_mem_bubble = 1'b1;
                        wait_nxt      = wait_inc;
                        if (wait_inc == TIMEOUT_VAL) begin
                            timeout_set = 1'b1;
                            state_nxt   = RUN;
                        end
                    end
                end

                default: state_nxt = RUN;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            wait_cnt   <= '0;
            mc_timeout <= 1'b0;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (timeout_set) begin
                mc_timeout <= 1'b1;
            end
            if (!pc_write && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (if_id_flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule
